vrf_issue_seq: RTL
==================

Name: vrf_issue_seq

Overview:
Single-instruction sequencer for the lane-parallel vector register file (vrf). It accepts one vector op (dest reg, three source regs, element count) over a valid/ready handshake. It steps the lanes through element groups by driving the per-lane read/write addresses and enables, then delays write enables by the fixed execute-pipe latency. It sits between the decode/issue stage and the vrf + lane ALUs, which supply write data.

Parameters:
els_p, 32, number of vector registers in the vrf
vlen_p, 8, max elements per vector
lanes_p, 4, parallel lanes
exe_lat_p, 2, cycles from read address presented to write data valid at vrf (>=1)
(derived) v_addr_w = clog2(els_p), l_addr_w = clog2(vlen_p), len_w = clog2(vlen_p+1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
v_i  in  1  op valid
ready_o  out  1  sequencer can accept an op
rd_i  in  v_addr_w  destination register
rs0_i / rs1_i / rs2_i  in  v_addr_w each  source registers
len_i  in  len_w  element count; values above vlen_p are clamped to vlen_p
r_reg0_addr_o / r_reg1_addr_o / r_reg2_addr_o  out  lanes_p*v_addr_w  per-lane source reg select (all lanes equal)
r_addr_o  out  lanes_p*l_addr_w  per-lane element index
r_v_o  out  lanes_p  per-lane read valid to ALU lanes
w_reg_addr_o  out  v_addr_w  destination register
w_addr_o  out  lanes_p*l_addr_w  per-lane write element index
w_en_o  out  lanes_p  per-lane write enable
done_o  out  1  one-cycle completion pulse

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN.
- ready_o = (state==IDLE). Accept occurs on v_i & ready_o: latch rd/rs0-2 and clamped len.
- Group count G = ceil(len/lanes_p).
- Accept with len>0 -> ISSUE. Accept with len==0 -> stay IDLE, assert done_o the next cycle, no reads or writes.
- ISSUE: group counter g = 0..G-1, one group per cycle.
  - Lane i element e = g*lanes_p+i.
  - r_v_o[i] = (e < len).
  - r_addr_o[i] = e when valid, else 0.
  - Reg selects = latched rs0/rs1/rs2.
  - After g==G-1: go to DRAIN.
- Timing: accept at cycle 0 -> group k presented at cycle 1+k.
- Write path: exe_lat_p-deep shift register of {r_v mask, per-lane element index}.
  - w_en_o and w_addr_o at cycle t equal r_v_o and r_addr_o from cycle t-exe_lat_p.
  - w_reg_addr_o holds latched rd from accept until done.
- DRAIN: ends after the last write cycle (1+(G-1)+exe_lat_p), then return to IDLE.
- done_o: asserted for exactly one cycle in the first IDLE cycle after drain (cycle G+exe_lat_p+1). ready_o is also high that cycle, so a back-to-back op may be accepted in the done cycle.
- Idle outputs: r_v_o=0, w_en_o=0, all address outputs 0 except w_reg_addr_o (holds last rd).
- vlen_p need not be a multiple of lanes_p. Lanes of the final partial group are masked via r_v_o/w_en_o.
- Hazards:
  - rd equal to any rs is legal: element-wise, and each element is read before it is written.
  - No cross-op forwarding, since ops are serialized.
- Reset (async, any time including mid-op): state IDLE; counters, shift register and latched fields cleared; w_en_o=0, r_v_o=0, done_o=0, all addresses 0; ready_o=1 once reset deasserts. In-flight writes are dropped.
- v_i while not ready: ignored, inputs not sampled.

Test Plan:
- lanes 4, lat 2, len 8, rd=5, rs0=1, rs1=2, rs2=3, accept at c0 -> c1 r_addr {0,1,2,3}, r_v 1111, reg selects 1/2/3 all lanes; c2 {4,5,6,7}; w_en 1111 at c3 (addr 0-3) and c4 (addr 4-7), w_reg_addr 5; done_o at c5 only; ready_o low c1-c4.
- len 5 -> c2 r_v 0001, r_addr {4,0,0,0}; c4 w_en 0001, w_addr[0]=4; done c5.
- len 0 -> no r_v/w_en ever; done_o at c1; ready_o stays high.
- len 12 (clamped to 8) -> identical to scenario 1. v_i held high with a second op -> second op accepted in c5 (done cycle); its group 0 presented at c6.
- reset_i asserted at c3 of scenario 1 -> w_en_o drops to 0 immediately (asynchronous); no done_o; ready_o=1 after release; a new op then runs cleanly.
- rd==rs0==7, len 4 -> c1 read reg 7 elements 0-3; c3 write reg 7 elements 0-3; read addresses never observed after write for the same element.

Source files
------------

// File: rtl/vrf_issue_seq.sv
// Single-op sequencer for the lane-parallel vector register file: walks element
// groups across the lanes for reads, then replays the lane mask as write enables.
module vrf_issue_seq #(
  parameter int els_p     = 32,
  parameter int vlen_p    = 8,
  parameter int lanes_p   = 4,
  parameter int exe_lat_p = 2,
  localparam int v_addr_w = $clog2(els_p),
  localparam int l_addr_w = $clog2(vlen_p),
  localparam int len_w    = $clog2(vlen_p + 1)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  logic [v_addr_w-1:0]           rd_i,
  input  logic [v_addr_w-1:0]           rs0_i,
  input  logic [v_addr_w-1:0]           rs1_i,
  input  logic [v_addr_w-1:0]           rs2_i,
  input  logic [len_w-1:0]              len_i,
  output logic [lanes_p*v_addr_w-1:0]   r_reg0_addr_o,
  output logic [lanes_p*v_addr_w-1:0]   r_reg1_addr_o,
  output logic [lanes_p*v_addr_w-1:0]   r_reg2_addr_o,
  output logic [lanes_p*l_addr_w-1:0]   r_addr_o,
  output logic [lanes_p-1:0]            r_v_o,
  output logic [v_addr_w-1:0]           w_reg_addr_o,
  output logic [lanes_p*l_addr_w-1:0]   w_addr_o,
  output logic [lanes_p-1:0]            w_en_o,
  output logic                          done_o
);

  // Element base counter must hold one group past the last valid element.
  localparam int cnt_w  = $clog2(vlen_p + lanes_p + 1);
  localparam int dcnt_w = $clog2(exe_lat_p + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                      state_q, state_d;
  logic [cnt_w-1:0]            base_q, base_d;
  logic [dcnt_w-1:0]           dcnt_q, dcnt_d;
  logic [len_w-1:0]            len_q, len_d;
  logic [len_w-1:0]            len_c;
  logic [v_addr_w-1:0]         rd_q, rd_d, rs0_q, rs0_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                        done_q, done_d;
  logic [cnt_w-1:0]            e;

  logic [lanes_p-1:0]          r_v_q, r_v_d;
  logic [lanes_p*l_addr_w-1:0] r_addr_q, r_addr_d;
  logic [lanes_p*v_addr_w-1:0] rsel0_q, rsel0_d, rsel1_q, rsel1_d, rsel2_q, rsel2_d;

  logic [lanes_p-1:0]          wv_q [exe_lat_p];
  logic [lanes_p-1:0]          wv_d [exe_lat_p];
  logic [lanes_p*l_addr_w-1:0] wa_q [exe_lat_p];
  logic [lanes_p*l_addr_w-1:0] wa_d [exe_lat_p];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    dcnt_d  = dcnt_q;
    len_d   = len_q;
    rd_d    = rd_q;
    rs0_d   = rs0_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    done_d  = 1'b0;
    len_c   = (len_i > len_w'(vlen_p)) ? len_w'(vlen_p) : len_i;
    unique case (state_q)
      IDLE: begin
        if (v_i) begin
          rd_d   = rd_i;
          rs0_d  = rs0_i;
          rs1_d  = rs1_i;
          rs2_d  = rs2_i;
          len_d  = len_c;
          base_d = '0;
          dcnt_d = '0;
          if (len_c == '0) done_d = 1'b1;
          else             state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (base_q + cnt_w'(lanes_p) >= cnt_w'(len_q)) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          base_d = base_q + cnt_w'(lanes_p);
        end
      end
      DRAIN: begin
        if (dcnt_q == dcnt_w'(exe_lat_p - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + dcnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read-side outputs are registered: derive next cycle's group from next state.
  always_comb begin
    r_v_d    = '0;
    r_addr_d = '0;
    rsel0_d  = '0;
    rsel1_d  = '0;
    rsel2_d  = '0;
    e        = '0;
    if (state_d == ISSUE) begin
      rsel0_d = {lanes_p{rs0_d}};
      rsel1_d = {lanes_p{rs1_d}};
      rsel2_d = {lanes_p{rs2_d}};
      for (int i = 0; i < lanes_p; i++) begin
        e = base_d + cnt_w'(i);
        if (e < cnt_w'(len_d)) begin
          r_v_d[i]                         = 1'b1;
          r_addr_d[i*l_addr_w +: l_addr_w] = e[l_addr_w-1:0];
        end
      end
    end
  end

  always_comb begin
    wv_d[0] = r_v_q;
    wa_d[0] = r_addr_q;
    for (int k = 1; k < exe_lat_p; k++) begin
      wv_d[k] = wv_q[k-1];
      wa_d[k] = wa_q[k-1];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      base_q   <= '0;
      dcnt_q   <= '0;
      len_q    <= '0;
      rd_q     <= '0;
      rs0_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      done_q   <= 1'b0;
      r_v_q    <= '0;
      r_addr_q <= '0;
      rsel0_q  <= '0;
      rsel1_q  <= '0;
      rsel2_q  <= '0;
      for (int k = 0; k < exe_lat_p; k++) begin
        wv_q[k] <= '0;
        wa_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      dcnt_q   <= dcnt_d;
      len_q    <= len_d;
      rd_q     <= rd_d;
      rs0_q    <= rs0_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      done_q   <= done_d;
      r_v_q    <= r_v_d;
      r_addr_q <= r_addr_d;
      rsel0_q  <= rsel0_d;
      rsel1_q  <= rsel1_d;
      rsel2_q  <= rsel2_d;
      for (int k = 0; k < exe_lat_p; k++) begin
        wv_q[k] <= wv_d[k];
        wa_q[k] <= wa_d[k];
      end
    end
  end

  assign ready_o       = (state_q == IDLE);
  assign r_v_o         = r_v_q;
  assign r_addr_o      = r_addr_q;
  assign r_reg0_addr_o = rsel0_q;
  assign r_reg1_addr_o = rsel1_q;
  assign r_reg2_addr_o = rsel2_q;
  assign w_en_o        = wv_q[exe_lat_p-1];
  assign w_addr_o      = wa_q[exe_lat_p-1];
  assign w_reg_addr_o  = rd_q;
  assign done_o        = done_q;

endmodule
